fpu_issue_wb: RTL and testbench

- Sequencing and writeback stage wrapped around the FPU arithmetic top.
- Accepts one FP operation at a time from the core pipeline through a valid/ready request port, latches the operands, and holds start/op/operands stable toward the arithmetic unit until its done is seen.
- Captures the result and exception flags, presents them on a valid/ready response port, and owns the fcsr state (frm, fflags accrual).
- Supplies frm as the dynamic rounding mode to the arithmetic unit.

---
 rtl/fpu_issue_wb.sv | 132 +++++++++++++
 tb/tb_fpu_issue_wb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_wb.sv
// Issue/writeback sequencer around the FPU arithmetic top: request latch, start/done
// handshake with a watchdog, response hold, and fcsr (frm + sticky fflags) ownership.
module fpu_issue_wb #(
  parameter int WDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_rm,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_rs2_lsb,
  input  logic [4:0]  req_rd,
  output logic        fpu_start,
  output logic [4:0]  fpu_op,
  output logic [2:0]  fpu_rm,
  output logic [2:0]  fpu_frm,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_rs2_lsb,
  input  logic [31:0] fpu_result,
  input  logic        fpu_done,
  input  logic        fpu_nv,
  input  logic        fpu_dz,
  input  logic        fpu_of,
  input  logic        fpu_uf,
  input  logic        fpu_nx,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  input  logic        csr_we,
  input  logic [7:0]  csr_wdata,
  output logic [7:0]  fcsr_o
);
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] wdog;
  logic [2:0]    frm;
  logic [4:0]    fflags;
  logic          rm_sensitive;
  logic          rm_illegal;
  logic          accrue;
  logic [4:0]    new_flags;

  // rm is only a rounding mode for these ops; elsewhere it selects a function
  always_comb begin
    rm_sensitive = 1'b0;
    case (req_op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011,
      5'b01011, 5'b11000, 5'b11010: rm_sensitive = 1'b1;
      default:                      rm_sensitive = 1'b0;
    endcase
    rm_illegal = rm_sensitive &&
                 ((req_rm == 3'b101) || (req_rm == 3'b110) ||
                  ((req_rm == 3'b111) && (frm >= 3'b101)));
  end

  assign accrue     = (state == BUSY) && fpu_done;
  assign new_flags  = {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx};
  assign req_ready  = (state == IDLE);
  assign fpu_start  = (state == BUSY);
  assign resp_valid = (state == RESP);
  assign fpu_frm    = frm;
  assign fcsr_o     = {frm, fflags};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wdog        <= '0;
      fpu_op      <= '0;
      fpu_rm      <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_rs2_lsb <= 1'b0;
      resp_data   <= '0;
      resp_rd     <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          fpu_op      <= req_op;
          fpu_rm      <= req_rm;
          fpu_a       <= req_a;
          fpu_b       <= req_b;
          fpu_rs2_lsb <= req_rs2_lsb;
          resp_rd     <= req_rd;
          resp_data   <= '0;
          wdog        <= '0;
          resp_err    <= rm_illegal;
          state       <= rm_illegal ? RESP : BUSY;
        end
        BUSY: begin
          if (fpu_done) begin
            resp_data <= fpu_result;
            resp_err  <= 1'b0;
            state     <= RESP;
          end else if (wdog == CW'(WDOG_CYCLES - 1)) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            state     <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A CSR write and a completing op in the same cycle both land: written flags OR new ones
  always_ff @(posedge clk) begin
    if (reset) begin
      frm    <= '0;
      fflags <= '0;
    end else if (csr_we) begin
      frm    <= csr_wdata[7:5];
      fflags <= csr_wdata[4:0] | (accrue ? new_flags : 5'b0);
    end else if (accrue) begin
      fflags <= fflags | new_flags;
    end
  end
endmodule

// File: tb/tb_fpu_issue_wb.sv
// Randomized scoreboard bench for fpu_issue_wb with a mock arithmetic unit of programmable latency.
module tb_fpu_issue_wb;
  localparam int WDOG = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_rm;
  logic [31:0] req_a, req_b;
  logic        req_rs2_lsb;
  logic [4:0]  req_rd;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rm, fpu_frm;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_rs2_lsb;
  logic [31:0] fpu_result;
  logic        fpu_done;
  logic        fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        csr_we;
  logic [7:0]  csr_wdata;
  logic [7:0]  fcsr_o;

  fpu_issue_wb #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .req_a(req_a), .req_b(req_b),
    .req_rs2_lsb(req_rs2_lsb), .req_rd(req_rd), .fpu_start(fpu_start),
    .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_frm(fpu_frm), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_rs2_lsb(fpu_rs2_lsb), .fpu_result(fpu_result),
    .fpu_done(fpu_done), .fpu_nv(fpu_nv), .fpu_dz(fpu_dz), .fpu_of(fpu_of),
    .fpu_uf(fpu_uf), .fpu_nx(fpu_nx), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_err(resp_err), .csr_we(csr_we), .csr_wdata(csr_wdata), .fcsr_o(fcsr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [2:0]  frm_m = 3'd0;
  logic [4:0]  ff_m  = 5'd0;
  logic [73:0] lat_fields = '0;
  logic [2:0]  busy_frm = 3'd0;
  logic [4:0]  sens_ops [7] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b11000, 5'b11010};

  // Mock arithmetic unit: done after mock_lat start cycles (0 = never)
  logic [31:0] mock_result = '0;
  logic [4:0]  mock_flags = '0;
  int          mock_lat = 1;
  logic [7:0]  mock_cnt = '0;
  logic        csr_we_r = 1'b0;
  logic        csr_at_done = 1'b0;

  always @(posedge clk) mock_cnt <= fpu_start ? mock_cnt + 8'd1 : 8'd0;
  assign fpu_done   = fpu_start && (mock_lat != 0) && (mock_cnt == 8'(mock_lat - 1));
  assign fpu_result = mock_result;
  assign {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = mock_flags;
  assign csr_we = csr_we_r | (csr_at_done & fpu_done);

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on handshake, checks hold stability and operand stability
  initial begin
    logic       hold_prev;
    logic [37:0] snap;
    exp_t       e;
    hold_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("resp_hold_valid", resp_valid, 1);
          chk("resp_hold_fields", {resp_data, resp_rd, resp_err}, snap);
        end
        if (fpu_start) begin
          chk("fpu_operands_stable", {fpu_op, fpu_rm, fpu_a, fpu_b, fpu_rs2_lsb}, lat_fields);
          chk("fpu_frm", fpu_frm, busy_frm);
        end
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_resp", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("resp_err", resp_err, e.err);
            chk("resp_data", resp_data, e.data);
            chk("resp_rd", resp_rd, e.rd);
          end
        end
        hold_prev = resp_valid && !resp_ready;
        snap = {resp_data, resp_rd, resp_err};
      end
    end
  end

  task automatic csr_write(input logic [7:0] v);
    csr_we_r = 1'b1;
    csr_wdata = v;
    @(posedge clk); #1;
    csr_we_r = 1'b0;
    frm_m = v[7:5];
    ff_m = v[4:0];
    chk("fcsr_write", fcsr_o, v);
  endtask

  task automatic do_op(input logic [4:0] op, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic rs, input logic [4:0] rd,
                       input logic [31:0] res, input logic [4:0] flg, input int lat,
                       input int hold, input bit csr_done, input logic [7:0] csr_val);
    bit sens, ill, wd, got;
    exp_t e;
    int starts, waits, exp_waits;
    sens = 1'b0;
    foreach (sens_ops[i]) if (sens_ops[i] == op) sens = 1'b1;
    ill = sens && (rm == 3'b101 || rm == 3'b110 || (rm == 3'b111 && frm_m >= 3'b101));
    wd = !ill && (lat == 0 || lat > WDOG);
    e.err = ill || wd;
    e.data = e.err ? 32'h0 : res;
    e.rd = rd;
    sb.push_back(e);
    exp_waits = ill ? 1 : (wd ? WDOG + 1 : lat + 1);
    lat_fields = {op, rm, a, b, rs};
    busy_frm = frm_m;
    mock_result = res;
    mock_flags = flg;
    mock_lat = lat;
    csr_wdata = csr_val;
    csr_at_done = csr_done;
    resp_ready = (hold == 0);
    waits = 0;
    while (!req_ready && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_rm = rm; req_a = a; req_b = b;
    req_rs2_lsb = rs; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 5'($urandom); req_rm = 3'($urandom);
    req_a = $urandom; req_b = $urandom; req_rs2_lsb = 1'($urandom); req_rd = 5'($urandom);
    starts = 0; got = 1'b0; waits = 0;
    for (int k = 1; k <= WDOG + 20; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        waits = k;
        break;
      end
      if (fpu_start) starts++;
    end
    chk("resp_arrived", got, 1);
    if (got) begin
      chk("resp_latency", waits, exp_waits);
      chk("start_cycles", starts, ill ? 0 : (wd ? WDOG : lat));
      if (hold > 0) begin
        repeat (hold) @(posedge clk);
        #1 resp_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    csr_at_done = 1'b0;
    if (!e.err) begin
      if (csr_done) begin
        frm_m = csr_val[7:5];
        ff_m = csr_val[4:0] | flg;
      end else begin
        ff_m = ff_m | flg;
      end
    end
    chk("resp_valid_drop", resp_valid, 0);
    chk("fcsr_after_op", fcsr_o, {frm_m, ff_m});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] op;
    int lat, r;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
    req_rs2_lsb = 1'b0; req_rd = '0; resp_ready = 1'b0; csr_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_fpu_start", fpu_start, 0);
    chk("rst_fcsr", fcsr_o, 8'h00);
    chk("rst_resp_data", {resp_data, resp_rd, resp_err}, 0);
    chk("rst_fpu_fields", {fpu_op, fpu_rm, fpu_a, fpu_b, fpu_rs2_lsb, fpu_frm}, 0);

    // FADD, single-cycle completion
    do_op(5'b00000, 3'b000, 32'h3F800000, 32'h40000000, 1'b0, 5'd3,
          32'h40400000, 5'b00000, 1, 0, 1'b0, 8'h00);
    // FDIV dynamic rm with frm=001, 25-cycle completion raising DZ
    csr_write(8'h20);
    do_op(5'b00011, 3'b111, 32'h3F800000, 32'h00000000, 1'b0, 5'd7,
          32'h7F800000, 5'b01000, 25, 1, 1'b0, 8'h00);
    chk("fdiv_fcsr", fcsr_o, 8'h28);
    // Illegal rounding modes on FMUL
    csr_write(8'hC0);
    do_op(5'b00010, 3'b101, 32'h1, 32'h2, 1'b0, 5'd9, 32'h12345678, 5'b11111, 1, 0, 1'b0, 8'h00);
    do_op(5'b00010, 3'b111, 32'h1, 32'h2, 1'b0, 5'd10, 32'h12345678, 5'b11111, 1, 2, 1'b0, 8'h00);
    chk("illegal_fcsr", fcsr_o, 8'hC0);
    // NX accrual coinciding with a CSR write
    csr_write(8'h00);
    do_op(5'b00000, 3'b000, 32'h3F800001, 32'h3F800001, 1'b0, 5'd11,
          32'h40000001, 5'b00001, 3, 0, 1'b1, 8'h40);
    chk("csr_accrue_fcsr", fcsr_o, 8'h41);
    // Watchdog abort with a stalled consumer
    do_op(5'b00100, 3'b000, 32'hAAAA5555, 32'h5555AAAA, 1'b1, 5'd12,
          32'hDEADBEEF, 5'b10000, 0, 5, 1'b0, 8'h00);

    // Reset in the third BUSY cycle
    csr_write(8'h25);
    mock_lat = 0;
    lat_fields = {5'b00100, 3'b000, 32'h11111111, 32'h22222222, 1'b0};
    busy_frm = frm_m;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 5'b00100; req_rm = 3'b000; req_a = 32'h11111111;
    req_b = 32'h22222222; req_rs2_lsb = 1'b0; req_rd = 5'd13;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_busy", fpu_start, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    frm_m = 3'd0; ff_m = 5'd0;
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_fpu_start", fpu_start, 0);
    chk("rst_mid_fcsr", fcsr_o, 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rst_mid_no_resp", resp_valid, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) csr_write(8'($urandom));
      op = ($urandom_range(0, 1) == 1) ? sens_ops[$urandom_range(0, 6)] : 5'($urandom);
      r = $urandom_range(0, 11);
      lat = (r == 0) ? 0 : r;
      do_op(op, 3'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom),
            $urandom, 5'($urandom), lat, $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
